// File: rtl/sumador_serial_pkg.sv
// Shared types and constants for the nibble-serial adder.
package sumador_serial_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sumador.sv
// 4-bit ripple-carry adder: the single arithmetic element reused every cycle.
module sumador
  import sumador_serial_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             carry_i,
  output logic [NIB_W-1:0] s_o,
  output logic             carry_o
);

  always_comb begin
    logic cy;
    cy  = carry_i;
    s_o = '0;
    for (int i = 0; i < NIB_W; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ cy;
      cy     = (a_i[i] & b_i[i]) | (cy & (a_i[i] ^ b_i[i]));
    end
    carry_o = cy;
  end

endmodule

// File: rtl/sumador_serial.sv
// Nibble-serial adder: one 4-bit adder, one nibble per cycle from the LSB up.
// Optional macro SUMADOR_SERIAL_SUB_EN adds op_i to select subtraction (A-B).
module sumador_serial
  import sumador_serial_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [NIB_W*NIBBLES-1:0] A_i,
  input  logic [NIB_W*NIBBLES-1:0] B_i,
  input  logic                     carry_i,
`ifdef SUMADOR_SERIAL_SUB_EN
  input  logic                     op_i,
`endif
  output logic                     busy_o,
  output logic                     done_o,
  output logic [NIB_W*NIBBLES-1:0] S_o,
  output logic                     carry_o
);

  localparam int unsigned W     = NIB_W * NIBBLES;
  localparam int unsigned IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     a_q, b_q;
  logic             c_q;
  logic [NIB_W-1:0] nib_a, nib_b, nib_s;
  logic             nib_c;
  logic [W-1:0]     b_load;
  logic             c_load;

  assign nib_a = a_q[idx_q*NIB_W +: NIB_W];
  assign nib_b = b_q[idx_q*NIB_W +: NIB_W];

  // Subtraction is A + ~B + 1; carry-out then means "no borrow".
`ifdef SUMADOR_SERIAL_SUB_EN
  assign b_load = op_i ? ~B_i : B_i;
  assign c_load = op_i ? 1'b1 : carry_i;
`else
  assign b_load = B_i;
  assign c_load = carry_i;
`endif

  sumador u_sumador (
    .a_i     (nib_a),
    .b_i     (nib_b),
    .carry_i (c_q),
    .s_o     (nib_s),
    .carry_o (nib_c)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (idx_q == IDX_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and status flags; flags follow the next state so they align with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      S_o     <= '0;
      carry_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      busy_o <= (state_d != IDLE);
      done_o <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q   <= A_i;
            b_q   <= b_load;
            c_q   <= c_load;
            idx_q <= '0;
          end
        end
        RUN: begin
          S_o[idx_q*NIB_W +: NIB_W] <= nib_s;
          c_q                       <= nib_c;
          idx_q                     <= idx_q + IDX_W'(1);
          // Final carry is published together with the done pulse.
          if (idx_q == IDX_LAST) carry_o <= nib_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serial.sv
// Self-checking bench for sumador_serial: directed steps plus a result scoreboard.
module tb_sumador_serial;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [W-1:0] A_i, B_i;
  logic         carry_i;
`ifdef SUMADOR_SERIAL_SUB_EN
  logic         op_i;
`endif
  logic         busy_o, done_o, carry_o;
  logic [W-1:0] S_o;

  sumador_serial #(.NIBBLES(NIB)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .A_i     (A_i),
    .B_i     (B_i),
    .carry_i (carry_i),
`ifdef SUMADOR_SERIAL_SUB_EN
    .op_i    (op_i),
`endif
    .busy_o  (busy_o),
    .done_o  (done_o),
    .S_o     (S_o),
    .carry_o (carry_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   m_cnt    = 0;

  logic [W:0]   m_r;
  logic [W-1:0] m_b;
  logic         m_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model of acceptance timing: one start every NIB+2 cycles at most.
  always @(posedge clk) begin
    cyc++;
    if (rst_i) begin
      m_cnt = 0;
      sb.delete();
    end else if (m_cnt == 0) begin
      if (start_i) begin
        m_b = B_i;
        m_c = carry_i;
`ifdef SUMADOR_SERIAL_SUB_EN
        if (op_i) begin
          m_b = ~B_i;
          m_c = 1'b1;
        end
`endif
        m_r = {1'b0, A_i} + {1'b0, m_b} + (W+1)'(m_c);
        sb.push_back('{s: m_r[W-1:0], c: m_r[W], cyc: cyc});
        m_cnt = NIB + 1;
      end
    end else begin
      m_cnt--;
    end
  end

  always @(negedge clk) begin
    if (done_o) begin
      exp_t e;
      done_cnt++;
      done_cyc.push_back(cyc);
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sum", 32'(S_o), 32'(e.s));
        chk("carry_out", 32'(carry_o), 32'(e.c));
        chk("latency", 32'(cyc - e.cyc), 32'(NIB));
        chk("busy_at_done", 32'(busy_o), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 40 && done_cnt < n; i++) @(negedge clk);
    chk("done_timeout", 32'(done_cnt >= n), 32'd1);
    tick();
  endtask

  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n0;
    n0      = done_cnt;
    start_i = 1'b1;
    A_i     = a;
    B_i     = b;
    carry_i = c;
    tick();
    start_i = 1'b0;
    A_i     = W'($urandom);
    B_i     = W'($urandom);
    carry_i = ~c;
    wait_done(n0 + 1);
  endtask

  initial begin
    int n0;
    rst_i   = 1'b1;
    start_i = 1'b0;
    A_i     = '0;
    B_i     = '0;
    carry_i = 1'b0;
`ifdef SUMADOR_SERIAL_SUB_EN
    op_i    = 1'b0;
`endif
    #2;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_sum", 32'(S_o), 32'd0);
    chk("rst_carry", 32'(carry_o), 32'd0);
    repeat (2) tick();
    rst_i = 1'b0;

    // Basic addition with latency and busy checks.
    start_i = 1'b1;
    A_i = 16'h1234;
    B_i = 16'h1111;
    carry_i = 1'b0;
    tick();
    start_i = 1'b0;
    A_i = 16'hDEAD;
    B_i = 16'hBEEF;
    carry_i = 1'b1;
    @(negedge clk);
    chk("busy_after_accept", 32'(busy_o), 32'd1);
    chk("no_early_done", 32'(done_o), 32'd0);
    wait_done(1);
    repeat (3) tick();
    chk("hold_sum", 32'(S_o), 32'h2345);
    chk("hold_carry", 32'(carry_o), 32'd0);
    chk("idle_busy", 32'(busy_o), 32'd0);

    run_add(16'h0000, 16'h0000, 1'b1);
    run_add(16'h8F3C, 16'h70C4, 1'b1);
    run_add(16'hA5A5, 16'h5A5B, 1'b0);
    run_add(16'hFFFF, 16'h0001, 1'b0);

    // Reset in the middle of RUN aborts without a done pulse.
    start_i = 1'b1;
    A_i = 16'h1111;
    B_i = 16'h1111;
    carry_i = 1'b0;
    tick();
    start_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b1;
    #1;
    chk("abort_sum", 32'(S_o), 32'd0);
    chk("abort_carry", 32'(carry_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    n0 = done_cnt;
    repeat (2) tick();
    rst_i = 1'b0;
    start_i = 1'b1;
    A_i = 16'hABCD;
    B_i = 16'h4321;
    carry_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(n0 + 1);
    chk("one_done_after_abort", 32'(done_cnt - n0), 32'd1);

    // start held high for ten cycles with operands changing every cycle.
    n0 = done_cnt;
    start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      A_i = W'($urandom);
      B_i = W'($urandom);
      carry_i = 1'($urandom);
      tick();
    end
    start_i = 1'b0;
    wait_done(n0 + 2);
    repeat (8) tick();
    chk("held_two_results", 32'(done_cnt - n0), 32'd2);
    if (done_cyc.size() >= 2)
      chk("held_done_gap", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2] - 1), 32'd5);

`ifdef SUMADOR_SERIAL_SUB_EN
    op_i = 1'b1;
    run_add(16'h0005, 16'h0007, 1'b0);
    chk("sub_neg_sum", 32'(S_o), 32'hFFFE);
    chk("sub_neg_borrow", 32'(carry_o), 32'd0);
    run_add(16'h0007, 16'h0005, 1'b0);
    chk("sub_pos_sum", 32'(S_o), 32'h0002);
    chk("sub_pos_noborrow", 32'(carry_o), 32'd1);
    op_i = 1'b0;
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
